// File: rtl/controle_seed.sv
// Seed-selection control FSM for PoliLobinho: counter clear, gated advance, ROM wait, seed load.
// Optional auto-confirm on idle timeout is built only when SEED_TIMEOUT_EN is defined.
module controle_seed #(
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       seed_pulso,
  input  logic       fim_jogo,
  output logic       zera_CS,
  output logic       conta_CS_en,
  output logic       e_seed_reg,
  output logic       seed_pronto,
  output logic       seed_auto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    SELECIONA  = 4'd2,
    ESPERA_ROM = 4'd3,
    REGISTRA   = 4'd4,
    PRONTO     = 4'd5
  } state_t;

  state_t state, next;
  logic   timeout_hit;

  if ((2 ** TW) < TIMEOUT) begin : g_tw_check
    $error("TW too narrow for TIMEOUT");
  end

`ifdef SEED_TIMEOUT_EN
  logic [TW-1:0] cnt;
  assign timeout_hit = (cnt == TW'(TIMEOUT - 1));

  // Counter only advances while staying in SELECIONA; any exit or button press restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == SELECIONA && next == SELECIONA && !seed_pulso) begin
      if (!timeout_hit) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seed_auto <= 1'b0;
    end else if (next == INICIAL || next == PREPARA) begin
      seed_auto <= 1'b0;
    end else if (state == SELECIONA && next == ESPERA_ROM && !confirmar) begin
      seed_auto <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign seed_auto   = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next = state;
    case (state)
      INICIAL:    if (iniciar) next = PREPARA;
      PREPARA:    next = SELECIONA;
      SELECIONA:  if (confirmar || (timeout_hit && !seed_pulso)) next = ESPERA_ROM;
      ESPERA_ROM: next = REGISTRA;
      REGISTRA:   next = PRONTO;
      PRONTO:     next = PRONTO;
      default:    next = INICIAL;
    endcase
    if (fim_jogo) next = INICIAL;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // Outputs are registered from the next state, so they track the state register with no input path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= INICIAL;
      db_estado   <= 4'd0;
      zera_CS     <= 1'b0;
      conta_CS_en <= 1'b0;
      e_seed_reg  <= 1'b0;
      seed_pronto <= 1'b0;
    end else begin
      state       <= next;
      db_estado   <= next;
      zera_CS     <= (next == PREPARA);
      conta_CS_en <= (next == SELECIONA);
      e_seed_reg  <= (next == REGISTRA);
      seed_pronto <= (next == PRONTO);
    end
  end

endmodule

// File: tb/tb_controle_seed.sv
// Directed self-checking bench for controle_seed with a small counter/ROM/seed-register datapath model.
// Build with SEED_TIMEOUT_EN defined to exercise the auto-confirm timeout (TIMEOUT=8).
module tb_controle_seed;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, confirmar = 1'b0, seed_pulso = 1'b0, fim_jogo = 1'b0;
  logic       zera_CS, conta_CS_en, e_seed_reg, seed_pronto, seed_auto;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  logic [3:0] addr;
  logic [7:0] rom_q, seed_reg;
  int         load_count = 0;

  controle_seed #(.TIMEOUT(8), .TW(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .confirmar(confirmar),
    .seed_pulso(seed_pulso), .fim_jogo(fim_jogo), .zera_CS(zera_CS),
    .conta_CS_en(conta_CS_en), .e_seed_reg(e_seed_reg), .seed_pronto(seed_pronto),
    .seed_auto(seed_auto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rom(input logic [3:0] a);
    return 8'(a * 17 + 5);
  endfunction

  // Datapath model: seed counter, synchronous ROM, seed register.
  always_ff @(posedge clock) begin
    if (zera_CS) addr <= 4'd0;
    else if (conta_CS_en && seed_pulso) addr <= addr + 4'd1;
    rom_q <= rom(addr);
    if (e_seed_reg) begin
      seed_reg   <= rom_q;
      load_count <= load_count + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enter_select();
    iniciar = 1'b1; step(); iniciar = 1'b0; step();
  endtask

  task automatic pulse_seed(input int n);
    for (int i = 0; i < n; i++) begin
      seed_pulso = 1'b1; step(); seed_pulso = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", db_estado); end
    checks++;
    if ({zera_CS, conta_CS_en, e_seed_reg, seed_pronto, seed_auto} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {zera_CS, conta_CS_en, e_seed_reg, seed_pronto, seed_auto});
    end
  endtask

  task automatic test_select();
    iniciar = 1'b1; step(); iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'd1 || zera_CS !== 1'b1) begin
      errors++; $display("FAIL prepara: state %0d zera %b want 1/1", db_estado, zera_CS);
    end
    step();
    checks++;
    if (db_estado !== 4'd2 || zera_CS !== 1'b0 || conta_CS_en !== 1'b1) begin
      errors++; $display("FAIL seleciona: state %0d zera %b en %b want 2/0/1", db_estado, zera_CS, conta_CS_en);
    end
    pulse_seed(3);
    confirmar = 1'b1; step(); confirmar = 1'b0;
    checks++;
    if (db_estado !== 4'd3 || conta_CS_en !== 1'b0 || e_seed_reg !== 1'b0) begin
      errors++; $display("FAIL espera_rom: state %0d en %b load %b want 3/0/0", db_estado, conta_CS_en, e_seed_reg);
    end
    step();
    checks++;
    if (db_estado !== 4'd4 || e_seed_reg !== 1'b1) begin
      errors++; $display("FAIL registra: state %0d load %b want 4/1", db_estado, e_seed_reg);
    end
    step();
    checks++;
    if (db_estado !== 4'd5 || seed_pronto !== 1'b1 || e_seed_reg !== 1'b0) begin
      errors++; $display("FAIL pronto: state %0d pronto %b load %b want 5/1/0", db_estado, seed_pronto, e_seed_reg);
    end
    checks++;
    if (seed_reg !== 8'h38 || addr !== 4'd3 || seed_auto !== 1'b0) begin
      errors++; $display("FAIL seed_rom3: seed %h addr %0d auto %b want 38/3/0", seed_reg, addr, seed_auto);
    end
  endtask

  task automatic test_mid_reset();
    step(); #2;
    reset = 1'b1; #1;
    checks++;
    if (db_estado !== 4'd0 || seed_pronto !== 1'b0) begin
      errors++; $display("FAIL async_reset: state %0d pronto %b want 0/0", db_estado, seed_pronto);
    end
    step(); reset = 1'b0; step();
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL after_reset: state %0d want 0", db_estado); end
  endtask

  task automatic test_same_cycle();
    enter_select();
    pulse_seed(5);
    confirmar = 1'b1; seed_pulso = 1'b1; step(); confirmar = 1'b0; seed_pulso = 1'b0;
    checks++;
    if (db_estado !== 4'd3) begin errors++; $display("FAIL same_cycle_exit: state %0d want 3", db_estado); end
    step(); step();
    checks++;
    if (seed_reg !== 8'h6B || addr !== 4'd6 || seed_auto !== 1'b0 || seed_pronto !== 1'b1) begin
      errors++;
      $display("FAIL seed_rom6: seed %h addr %0d auto %b pronto %b want 6b/6/0/1", seed_reg, addr, seed_auto, seed_pronto);
    end
    fim_jogo = 1'b1; step(); fim_jogo = 1'b0;
    checks++;
    if (db_estado !== 4'd0 || seed_pronto !== 1'b0) begin
      errors++; $display("FAIL pronto_abort: state %0d pronto %b want 0/0", db_estado, seed_pronto);
    end
  endtask

  task automatic test_abort();
    int loads;
    enter_select();
    confirmar = 1'b1; step(); confirmar = 1'b0;
    loads = load_count;
    fim_jogo = 1'b1; step(); fim_jogo = 1'b0;
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL abort_state: state %0d want 0", db_estado); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (e_seed_reg !== 1'b0 || db_estado !== 4'd0) begin
        errors++; $display("FAIL abort_load: cycle %0d load %b state %0d want 0/0", i, e_seed_reg, db_estado);
      end
      step();
    end
    checks++;
    if (load_count !== loads) begin errors++; $display("FAIL abort_count: loads %0d want %0d", load_count, loads); end
  endtask

  task automatic test_ignore();
    confirmar = 1'b1; step(); confirmar = 1'b0;
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL confirm_in_idle: state %0d want 0", db_estado); end
    enter_select();
    iniciar = 1'b1; step(); iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'd2) begin errors++; $display("FAIL iniciar_in_sel: state %0d want 2", db_estado); end
    fim_jogo = 1'b1; step(); fim_jogo = 1'b0;
  endtask

`ifdef SEED_TIMEOUT_EN
  task automatic test_timeout(input int pulse_cycle, input int want);
    int n = 0;
    enter_select();
    while (db_estado !== 4'd3 && n < 40) begin
      seed_pulso = (n + 1 == pulse_cycle);
      step();
      seed_pulso = 1'b0;
      n++;
    end
    checks++;
    if (n !== want) begin errors++; $display("FAIL timeout_exit: cycles %0d want %0d", n, want); end
    step(); step();
    checks++;
    if (db_estado !== 4'd5 || seed_auto !== 1'b1) begin
      errors++; $display("FAIL timeout_auto: state %0d auto %b want 5/1", db_estado, seed_auto);
    end
    fim_jogo = 1'b1; step(); fim_jogo = 1'b0;
    checks++;
    if (seed_auto !== 1'b0) begin errors++; $display("FAIL auto_clear: auto %b want 0", seed_auto); end
  endtask
`else
  task automatic test_no_timeout();
    enter_select();
    repeat (10000) step();
    checks++;
    if (db_estado !== 4'd2 || seed_auto !== 1'b0) begin
      errors++; $display("FAIL no_timeout: state %0d auto %b want 2/0", db_estado, seed_auto);
    end
    fim_jogo = 1'b1; step(); fim_jogo = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_mid_reset();
    test_same_cycle();
    test_abort();
    test_ignore();
`ifdef SEED_TIMEOUT_EN
    test_timeout(0, 8);
    test_timeout(5, 13);
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_seed.md
# controle_seed

Control unit for the seed-selection datapath of PoliLobinho. It sequences the seed counter clear, gates button-driven seed advancing and waits out the synchronous seed ROM read latency. It then pulses the seed register load and reports when the game seed is locked. It sits beside the datapath in the top level and drives its `zera_CS`, counter-enable and `e_seed_reg` controls.

## Interface
- `TIMEOUT`, default 1000: idle cycles in selection before auto-confirm (only with `SEED_TIMEOUT_EN`).
- `TW`, default 10: width of the timeout counter; must satisfy 2^TW ≥ TIMEOUT.
- `clock` in, 1: system clock, rising edge.
- `reset` in, 1: asynchronous, active-high; forces INICIAL.
- `iniciar` in, 1: start seed selection (level, sampled in INICIAL only).
- `confirmar` in, 1: player confirms the current seed (single-cycle pulse).
- `seed_pulso` in, 1: datapath button edge pulse (`inc_seed`); restarts the timeout.
- `fim_jogo` in, 1: abort/end game; returns to INICIAL.
- `zera_CS` out, 1: clear the seed address counter.
- `conta_CS_en` out, 1: permit the seed counter to advance on `seed_pulso`.
- `e_seed_reg` out, 1: load enable for the seed register.
- `seed_pronto` out, 1: seed locked, game may proceed.
- `seed_auto` out, 1: the locked seed came from a timeout, not from `confirmar`.
- `db_estado` out, 4: state code for the debug display.

## Operation
- Moore FSM. Codes: INICIAL=0, PREPARA=1, SELECIONA=2, ESPERA_ROM=3, REGISTRA=4, PRONTO=5. Codes 6–15 are unused and go to INICIAL on the next edge.
- INICIAL: all control outputs 0. `iniciar`=1 → PREPARA.
- PREPARA: `zera_CS`=1 for exactly one cycle → SELECIONA.
- SELECIONA: `conta_CS_en`=1. `confirmar`=1 → ESPERA_ROM.
- ESPERA_ROM: `conta_CS_en`=0, freezing the address; one cycle for the ROM output → REGISTRA.
- REGISTRA: `e_seed_reg`=1 for exactly one cycle → PRONTO.
- PRONTO: `seed_pronto`=1; holds until `fim_jogo`.
- `fim_jogo`=1 in any state other than INICIAL → INICIAL on the next edge. It has priority over every other input.
- `iniciar` is ignored outside INICIAL. `confirmar` is ignored outside SELECIONA.
- Simultaneous `confirmar` and `seed_pulso` in SELECIONA: the transition to ESPERA_ROM is taken. The counter still advances on that edge because `conta_CS_en` is high, so the post-increment seed is the one registered.
- `seed_auto` is a registered flag. It is set on a timeout transition, held through PRONTO and cleared on entry to INICIAL or PREPARA.

## Timing
- Reset values: state INICIAL, `db_estado`=0, and `zera_CS`, `conta_CS_en`, `e_seed_reg`, `seed_pronto`, `seed_auto` all 0. The timeout counter resets to 0.
- Reset mid-operation takes effect asynchronously. A pending `e_seed_reg` is dropped immediately.
- Latency:
  - `iniciar` sampled at edge k → PREPARA in cycle k+1 → SELECIONA at k+2.
  - `confirmar` at edge c → ESPERA_ROM at c+1, REGISTRA at c+2, `seed_pronto`=1 at c+3.
  - The seed register captures the ROM data at edge c+3.
- All outputs are decoded from the state and `seed_auto` flops only; no input-to-output combinational path.

## Configuration
- Macro: `SEED_TIMEOUT_EN`.
- Defined:
  - A TW-bit counter runs only in SELECIONA. It clears on entry to SELECIONA and on every `seed_pulso`.
  - When it reaches TIMEOUT-1 without `confirmar`, the FSM goes to ESPERA_ROM and sets `seed_auto`.
  - If `confirmar` arrives in the same cycle, this counts as a normal confirm and `seed_auto` stays 0.
  - The counter saturates at TIMEOUT-1 (no wrap-around).
- Undefined: no counter is instantiated, `seed_auto` is tied to 0, and SELECIONA leaves only on `confirmar` or `fim_jogo`.

## Test plan
- Reset asserted mid-cycle while in PRONTO → `db_estado`=0 and `seed_pronto`=0 immediately, with no clock edge needed.
- `iniciar` pulse, 3 `seed_pulso` pulses, then `confirmar` → `zera_CS` high exactly 1 cycle, `e_seed_reg` high exactly 1 cycle 2 cycles after `confirmar`, `seed_pronto`=1 one cycle later, and the registered seed equals ROM[3].
- `confirmar` and `seed_pulso` in the same cycle after 5 prior pulses → the registered seed equals ROM[6] and `seed_auto`=0.
- `fim_jogo` asserted in ESPERA_ROM → next state INICIAL, `e_seed_reg` never asserted, `db_estado`=0.
- `SEED_TIMEOUT_EN` with TIMEOUT=8: enter SELECIONA with no inputs → ESPERA_ROM after 8 cycles, `seed_auto`=1 in PRONTO. A `seed_pulso` at cycle 5 delays the exit to cycle 13.
- `SEED_TIMEOUT_EN` undefined: 10000 idle cycles in SELECIONA → still SELECIONA (`db_estado`=2) and `seed_auto`=0.
